decode_stage: RTL and testbench

- RV32I instruction-decode stage sitting directly upstream of register_file.
- Drives register_file read addresses A1/A2 from the incoming instruction and captures RD1/RD2 together with decoded control and the immediate into an ID/EX pipeline register.
- Uses a valid/ready handshake on both sides, inserts a one-cycle bubble on load-use hazards, and honours a flush from the branch-resolution logic.

---
 rtl/riscv_pkg.sv | 70 +++++++
 rtl/imm_gen.sv | 34 +++
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32I decode constants: opcodes, funct3 values, ALU operation encoding and
// the decoded control bundle carried in the ID/EX register.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, alu_src: 1'b0, reg_write: 1'b0,
                                 mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0,
                                 jump: 1'b0, illegal: 1'b0};

  // alt selects SUB/SRA, the only two funct3 values with a funct7[5] variant.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_from_f3 = ALU_SLL;
      F3_SLT:     alu_from_f3 = ALU_SLT;
      F3_SLTU:    alu_from_f3 = ALU_SLTU;
      F3_XOR:     alu_from_f3 = ALU_XOR;
      F3_SR:      alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_from_f3 = ALU_OR;
      default:    alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; unknown opcodes yield zero.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm;

  always_comb begin
    w_imm = '0;
    case (i_instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                 i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm = {i_instr[31:12], 12'b0};
      OPC_JAL:
        w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                 i_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  assign o_imm = XLEN'(w_imm);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage feeding the ID/EX register, with load-use bubble and flush.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle writeback data into operands.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val;
  logic            w_uses_rs1, w_uses_rs2, w_hz, w_adv;
  ctrl_t           w_ctrl;

  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  ctrl_t           r_ctrl;

  assign w_opc = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_f3  = in_instr[14:12];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];
  assign w_f7  = in_instr[31:25];

  assign rf_a1 = w_rs1;
  assign rf_a2 = w_rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (in_instr),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_ctrl = CTRL_NOP;
    case (w_opc)
      OPC_OP: begin
        w_ctrl.reg_write = 1'b1;
        if (w_f7 == F7_BASE)
          w_ctrl.alu_op = alu_from_f3(w_f3, 1'b0);
        else if (w_f7 == F7_ALT && (w_f3 == F3_ADD_SUB || w_f3 == F3_SR))
          w_ctrl.alu_op = alu_from_f3(w_f3, 1'b1);
        else
          w_ctrl.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = alu_from_f3(w_f3, 1'b0);
        // funct7 is only an opcode extension for shifts; elsewhere it is imm bits.
        if (w_f3 == F3_SLL && w_f7 != F7_BASE)
          w_ctrl.illegal = 1'b1;
        if (w_f3 == F3_SR) begin
          if (w_f7 == F7_ALT)       w_ctrl.alu_op  = ALU_SRA;
          else if (w_f7 != F7_BASE) w_ctrl.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl.alu_op = ALU_SUB;
        w_ctrl.branch = 1'b1;
      end
      OPC_LUI: begin
        w_ctrl.alu_op    = ALU_PASS_B;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump      = 1'b1;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
    if (w_ctrl.illegal) begin
      w_ctrl         = CTRL_NOP;
      w_ctrl.illegal = 1'b1;
    end
    if (w_rd == 5'd0)
      w_ctrl.reg_write = 1'b0;
  end

  assign w_uses_rs1 = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL);
  assign w_uses_rs2 = (w_opc == OPC_OP || w_opc == OPC_STORE || w_opc == OPC_BRANCH);

  assign w_hz = in_valid && r_valid && r_ctrl.mem_read && (r_rd != 5'd0) &&
                ((w_uses_rs1 && w_rs1 == r_rd) || (w_uses_rs2 && w_rs2 == r_rd));
  assign w_adv    = !r_valid || out_ready;
  assign in_ready = w_adv && !w_hz && !flush;

`ifdef DECODE_WB_BYPASS_EN
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                     (wb_we && wb_rd == w_rs1) ? wb_wd : rf_rd1;
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                     (wb_we && wb_rd == w_rs2) ? wb_wd : rf_rd2;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_we, wb_rd, wb_wd};
  assign w_rs1_val   = (w_rs1 == 5'd0) ? '0 : rf_rd1;
  assign w_rs2_val   = (w_rs2 == 5'd0) ? '0 : rf_rd2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_ctrl    <= CTRL_NOP;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_adv && w_hz) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid   <= in_valid;
      r_pc      <= in_pc;
      r_rs1_val <= w_rs1_val;
      r_rs2_val <= w_rs2_val;
      r_imm     <= w_imm;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_ctrl    <= w_ctrl;
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_rs1_val   = r_rs1_val;
  assign out_rs2_val   = r_rs2_val;
  assign out_imm       = r_imm;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_rd        = r_rd;
  assign out_alu_op    = r_ctrl.alu_op;
  assign out_alu_src   = r_ctrl.alu_src;
  assign out_reg_write = r_ctrl.reg_write;
  assign out_mem_read  = r_ctrl.mem_read;
  assign out_mem_write = r_ctrl.mem_write;
  assign out_branch    = r_ctrl.branch;
  assign out_jump      = r_ctrl.jump;
  assign out_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plan steps then random traffic against a
// cycle model of the ID/EX register built from the RV32I decode rules.
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready, wb_we;
  logic [31:0] in_instr, in_pc, rf_rd1, rf_rd2, wb_wd;
  logic [4:0]  wb_rd;
  logic        in_ready, out_valid;
  logic [4:0]  rf_a1, rf_a2, out_rs1, out_rs2, out_rd;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [3:0]  out_alu_op;
  logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_jump(out_jump), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc, r1v, r2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src, rw, mr, mw, br, jp, ill;
  } st_t;

  st_t m;

  // R/I-type funct3 -> ALU code, following the package numbering.
  int alu_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic st_t obs();
    st_t s;
    s = '{v: out_valid, pc: out_pc, r1v: out_rs1_val, r2v: out_rs2_val, imm: out_imm,
          rs1: out_rs1, rs2: out_rs2, rd: out_rd, op: out_alu_op, src: out_alu_src,
          rw: out_reg_write, mr: out_mem_read, mw: out_mem_write, br: out_branch,
          jp: out_jump, ill: out_illegal};
    return s;
  endfunction

  function automatic st_t reset_state();
    st_t s = '0;
    s.pc = RST_PC;
    return s;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && wb_rd == idx) return wb_wd;
`endif
    return rf;
  endfunction

  // Decode of the instruction currently on the input, from the ISA rules.
  function automatic st_t decode_in();
    st_t s = '0;
    logic [31:0] i = in_instr;
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    int t;
    s.pc = in_pc; s.rs1 = i[19:15]; s.rs2 = i[24:20]; s.rd = i[11:7];
    s.r1v = operand(s.rs1, rf_rd1);
    s.r2v = operand(s.rs2, rf_rd2);
    case (i[6:0])
      7'h33: begin
        s.rw = 1;
        if (f7 == 0) s.op = 4'(alu_tbl[f3]);
        else if (f7 == 7'h20 && f3 == 0) s.op = 4'd1;
        else if (f7 == 7'h20 && f3 == 5) s.op = 4'd7;
        else s.ill = 1;
      end
      7'h13: begin
        s.src = 1; s.rw = 1; s.op = 4'(alu_tbl[f3]);
        t = $signed(i[31:20]); s.imm = t;
        if (f3 == 1 && f7 != 0) s.ill = 1;
        if (f3 == 5 && f7 == 7'h20) s.op = 4'd7;
        else if (f3 == 5 && f7 != 0) s.ill = 1;
      end
      7'h03: begin s.src = 1; s.mr = 1; s.rw = 1; t = $signed(i[31:20]); s.imm = t; end
      7'h23: begin s.src = 1; s.mw = 1; t = $signed({i[31:25], i[11:7]}); s.imm = t; end
      7'h63: begin
        s.op = 4'd1; s.br = 1;
        t = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); s.imm = t;
      end
      7'h37: begin s.op = 4'd10; s.src = 1; s.rw = 1; s.imm = {i[31:12], 12'h000}; end
      7'h17: begin s.src = 1; s.rw = 1; s.imm = {i[31:12], 12'h000}; end
      7'h6F: begin
        s.src = 1; s.rw = 1; s.jp = 1;
        t = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); s.imm = t;
      end
      7'h67: begin s.src = 1; s.rw = 1; s.jp = 1; t = $signed(i[31:20]); s.imm = t; end
      default: s.ill = 1;
    endcase
    if (s.ill) begin s.op = 0; s.src = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.br = 0; s.jp = 0; end
    if (s.rd == 0) s.rw = 0;
    return s;
  endfunction

  // One clock: check combinational outputs, step the model, check the register.
  task automatic cyc();
    logic adv, hz, u1, u2;
    logic [6:0] opc;
    st_t nxt;
    #2;
    opc = in_instr[6:0];
    chk("rf_a1", 160'(rf_a1), 160'(in_instr[19:15]));
    chk("rf_a2", 160'(rf_a2), 160'(in_instr[24:20]));
    u1  = !(opc inside {7'h37, 7'h17, 7'h6F});
    u2  = opc inside {7'h33, 7'h23, 7'h63};
    adv = !m.v || out_ready;
    hz  = in_valid && m.v && m.mr && m.rd != 0 &&
          ((u1 && in_instr[19:15] == m.rd) || (u2 && in_instr[24:20] == m.rd));
    if (rst) chk("in_ready", 160'(in_ready), 160'(adv && !hz && !flush));
    nxt = decode_in();
    if (!rst) m = reset_state();
    else if (flush) m.v = 0;
    else if (adv && hz) m.v = 0;
    else if (adv) begin m = nxt; m.v = in_valid; end
    @(posedge clk);
    #1;
    chk("id_ex", 160'(obs()), 160'(m));
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    int sel = int'($urandom_range(0, 10));
    logic [6:0] f7;
    if (sel >= 9) return $urandom;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), opcs[sel]};
  endfunction

  initial begin
    m = reset_state();
    rst = 0; in_valid = 1; flush = 0; out_ready = 1; wb_we = 0; wb_rd = 0;
    in_instr = 32'h00500093; in_pc = 32'h100; rf_rd1 = 0; rf_rd2 = 0; wb_wd = 0;

    // Reset held two cycles with a valid instruction offered
    cyc(); cyc();
    chk("rst_valid", 160'(out_valid), 160'(0));
    chk("rst_pc", 160'(out_pc), 160'(RST_PC));
    chk("rst_aluop", 160'(out_alu_op), 160'(0));

    // addi x1,x0,5
    rst = 1; rf_rd1 = 32'hAAAA_5555;
    cyc();
    chk("addi_imm", 160'(out_imm), 160'(5));
    chk("addi_rs1v", 160'(out_rs1_val), 160'(0));
    chk("addi_flags", 160'({out_alu_src, out_reg_write, out_rd}), 160'({1'b1, 1'b1, 5'd1}));

    // Backpressure: add x3,x1,x2 held while EX stalls
    in_instr = 32'h002081B3; in_pc = 32'h104; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    cyc();
    out_ready = 0; in_instr = 32'h40208233; in_pc = 32'h108;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_rd", 160'(out_rd), 160'(3));
      chk("bp_in_ready", 160'(in_ready), 160'(0));
    end
    out_ready = 1;
    cyc();
    chk("bp_release", 160'({out_rd, out_alu_op}), 160'({5'd4, 4'd1}));

    // Load-use: lw x5,0(x1) ; add x6,x5,x2
    in_instr = 32'h0000A283; cyc();
    in_instr = 32'h00228333; cyc();
    chk("lu_bubble", 160'(out_valid), 160'(0));
    cyc();
    chk("lu_issue", 160'({out_valid, out_rs1}), 160'({1'b1, 5'd5}));
    in_instr = 32'h0000A283; cyc();
    in_instr = 32'h00238333; cyc();
    chk("lu_nobubble", 160'({out_valid, out_rs1}), 160'({1'b1, 5'd7}));

    // Flush while beq is held and a new instruction waits
    in_instr = 32'h00208063; cyc();
    chk("beq_branch", 160'({out_branch, out_alu_op}), 160'({1'b1, 4'd1}));
    out_ready = 0; flush = 1; in_instr = 32'h00500093;
    cyc();
    chk("flush_valid", 160'(out_valid), 160'(0));
    flush = 0; out_ready = 1;

    // Writeback bypass
    wb_we = 1; wb_rd = 2; wb_wd = 32'hDEADBEEF; rf_rd2 = 32'h12345678;
    in_instr = 32'h002081B3; cyc();
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_rs2", 160'(out_rs2_val), 160'(32'hDEADBEEF));
`else
    chk("byp_rs2", 160'(out_rs2_val), 160'(32'h12345678));
`endif
    wb_rd = 0; cyc();
    chk("byp_x0", 160'(out_rs2_val), 160'(32'h12345678));
    wb_we = 0;

    // Illegal word and rd=x0
    in_instr = 32'hFFFFFFFF; cyc();
    chk("ill", 160'({out_illegal, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}),
        160'(6'b100000));
    in_instr = 32'h00208033; cyc();
    chk("x0_rw", 160'({out_valid, out_reg_write}), 160'({1'b1, 1'b0}));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      rf_rd1    = $urandom;
      rf_rd2    = $urandom;
      wb_we     = $urandom_range(0, 1) == 1;
      wb_rd     = 5'($urandom_range(0, 7));
      wb_wd     = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
